// File: rtl/traffic_pkg.sv
// Shared state codes and lamp encodings for the intersection controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_HG    = 3'd0,
    ST_HY    = 3'd1,
    ST_AR_F  = 3'd2,
    ST_FG    = 3'd3,
    ST_FY    = 3'd4,
    ST_AR_H  = 3'd5,
    ST_FLASH = 3'd6
  } state_e;

  // Lamp groups are {green, yellow, red}.
  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_RED = 3'b001;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b100;

endpackage

// File: rtl/tl_phase_timer.sv
// Phase timer: clears on request, otherwise counts up and holds at all-ones.
module tl_phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_reset || i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt != C_MAX) begin
      r_cnt <= r_cnt + C_ONE;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/traffic_light_ctrl_param.sv
// Highway/farm-road intersection controller with pedestrian walk phase and
// maintenance flash. Lamps and walk decode directly from state and phase timer.
//
//  state | meaning
//  HG    | highway green, farm red
//  HY    | highway yellow, farm red
//  AR_F  | all red, clearing toward farm green
//  FG    | farm green (walk lamp may be lit)
//  FY    | farm yellow, highway red
//  AR_H  | all red, clearing toward highway green
//  FLASH | maintenance: highway yellow / farm red blinking
module traffic_light_ctrl_param
  import traffic_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int HWY_MIN_GREEN  = 8,
  parameter int FARM_MIN_GREEN = 4,
  parameter int FARM_MAX_GREEN = 12,
  parameter int YELLOW_TIME    = 3,
  parameter int ALLRED_TIME    = 2,
  parameter int WALK_TIME      = 6,
  parameter int FLASH_HALF     = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_sensor,
  input  logic       i_ped_req,
  input  logic       i_flash_mode,
  output logic [2:0] o_highway,
  output logic [2:0] o_farm,
  output logic       o_walk,
  output logic [2:0] o_phase
);

  localparam logic [CNT_W-1:0] C_HG_MIN    = CNT_W'(HWY_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] C_FG_MIN    = CNT_W'(FARM_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] C_FG_MAX    = CNT_W'(FARM_MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] C_YEL_LAST  = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] C_AR_LAST   = CNT_W'(ALLRED_TIME - 1);
  localparam logic [CNT_W-1:0] C_WALK_LAST = CNT_W'(WALK_TIME - 1);
  localparam logic [CNT_W-1:0] C_WALK      = CNT_W'(WALK_TIME);
  localparam logic [CNT_W-1:0] C_FL_HALF   = CNT_W'(FLASH_HALF);
  localparam logic [CNT_W-1:0] C_FL_PER    = CNT_W'(2 * FLASH_HALF);

  logic             r_sensor_m;
  logic             r_sensor_s;
  logic             r_ped_m;
  logic             r_ped_s;
  logic             r_ped_pending;
  logic             r_ped_served;
  state_e           r_state;
  state_e           w_next;
  logic             w_change;
  logic             w_enter_fg;
  logic             w_flash_on;
  logic [CNT_W-1:0] w_cnt;

  tl_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_change),
    .o_cnt   (w_cnt)
  );

  // Flash request pre-empts every timed exit.
  always_comb begin
    w_next = r_state;
    if (i_flash_mode && (r_state != ST_FLASH)) begin
      w_next = ST_FLASH;
    end else begin
      case (r_state)
        ST_HG: begin
          if ((w_cnt >= C_HG_MIN) && (r_sensor_s || r_ped_pending)) w_next = ST_HY;
        end
        ST_HY: begin
          if (w_cnt == C_YEL_LAST) w_next = ST_AR_F;
        end
        ST_AR_F: begin
          if (w_cnt == C_AR_LAST) w_next = ST_FG;
        end
        ST_FG: begin
          if ((w_cnt >= C_FG_MAX) ||
              ((w_cnt >= C_FG_MIN) && !r_sensor_s &&
               (!r_ped_served || (w_cnt >= C_WALK_LAST)))) begin
            w_next = ST_FY;
          end
        end
        ST_FY: begin
          if (w_cnt == C_YEL_LAST) w_next = ST_AR_H;
        end
        ST_AR_H: begin
          if (w_cnt == C_AR_LAST) w_next = ST_HG;
        end
        ST_FLASH: begin
          if (!i_flash_mode) w_next = ST_AR_H;
        end
        default: w_next = ST_HG;
      endcase
    end
  end

  assign w_change   = (w_next != r_state);
  assign w_enter_fg = (w_next == ST_FG) && (r_state != ST_FG);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_sensor_m    <= 1'b0;
      r_sensor_s    <= 1'b0;
      r_ped_m       <= 1'b0;
      r_ped_s       <= 1'b0;
      r_ped_pending <= 1'b0;
      r_ped_served  <= 1'b0;
      r_state       <= ST_HG;
    end else begin
      r_sensor_m <= i_sensor;
      r_sensor_s <= r_sensor_m;
      r_ped_m    <= i_ped_req;
      r_ped_s    <= r_ped_m;
      r_state    <= w_next;
      // A request arriving on the last all-red cycle is folded into this FG.
      if (w_enter_fg) begin
        r_ped_served  <= r_ped_pending | r_ped_s;
        r_ped_pending <= 1'b0;
      end else begin
        if (r_state != ST_FG) r_ped_served <= 1'b0;
        if ((r_state != ST_FG) && r_ped_s) r_ped_pending <= 1'b1;
      end
    end
  end

  assign w_flash_on = ((w_cnt % C_FL_PER) < C_FL_HALF);

  always_comb begin
    o_highway = LAMP_RED;
    o_farm    = LAMP_RED;
    case (r_state)
      ST_HG:    o_highway = LAMP_GRN;
      ST_HY:    o_highway = LAMP_YEL;
      ST_FG:    o_farm    = LAMP_GRN;
      ST_FY:    o_farm    = LAMP_YEL;
      ST_FLASH: begin
        o_highway = w_flash_on ? LAMP_YEL : LAMP_OFF;
        o_farm    = w_flash_on ? LAMP_RED : LAMP_OFF;
      end
      default: ;
    endcase
  end

  assign o_walk  = (r_state == ST_FG) && r_ped_served && (w_cnt < C_WALK);
  assign o_phase = r_state;

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Scoreboard bench: stimulus pushes per-cycle expected lamp/phase values,
// a negedge monitor pops and compares them against the controller outputs.
module tb_traffic_light_ctrl_param;

  localparam logic [2:0] P_HG    = 3'd0;
  localparam logic [2:0] P_HY    = 3'd1;
  localparam logic [2:0] P_AR_F  = 3'd2;
  localparam logic [2:0] P_FG    = 3'd3;
  localparam logic [2:0] P_FY    = 3'd4;
  localparam logic [2:0] P_AR_H  = 3'd5;
  localparam logic [2:0] P_FLASH = 3'd6;

  typedef struct packed {
    logic [2:0] ph;
    logic [2:0] hw;
    logic [2:0] fm;
    logic       wk;
  } exp_t;

  typedef struct {
    exp_t  e;
    string tag;
    int    idx;
  } item_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sensor = 1'b0;
  logic       ped_req = 1'b0;
  logic       flash_mode = 1'b0;
  logic [2:0] highway;
  logic [2:0] farm;
  logic       walk;
  logic [2:0] phase;

  item_t q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    push_idx = 0;

  always #5 clk = ~clk;

  traffic_light_ctrl_param #(
    .CNT_W          (16),
    .HWY_MIN_GREEN  (8),
    .FARM_MIN_GREEN (4),
    .FARM_MAX_GREEN (12),
    .YELLOW_TIME    (3),
    .ALLRED_TIME    (2),
    .WALK_TIME      (6),
    .FLASH_HALF     (4)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_sensor     (sensor),
    .i_ped_req    (ped_req),
    .i_flash_mode (flash_mode),
    .o_highway    (highway),
    .o_farm       (farm),
    .o_walk       (walk),
    .o_phase      (phase)
  );

  function automatic exp_t mk(input logic [2:0] ph, input logic wk);
    exp_t e;
    e.ph = ph;
    e.wk = wk;
    e.hw = 3'b001;
    e.fm = 3'b001;
    case (ph)
      P_HG: e.hw = 3'b100;
      P_HY: e.hw = 3'b010;
      P_FG: e.fm = 3'b100;
      P_FY: e.fm = 3'b010;
      default: ;
    endcase
    return e;
  endfunction

  task automatic push_seg(input string tag, input logic [2:0] ph, input int n, input logic wk);
    item_t it;
    for (int k = 0; k < n; k++) begin
      it.e   = mk(ph, wk);
      it.tag = tag;
      it.idx = push_idx;
      push_idx++;
      q.push_back(it);
    end
  endtask

  task automatic push_flash(input string tag, input int n);
    item_t it;
    for (int k = 0; k < n; k++) begin
      it.e.ph = P_FLASH;
      it.e.wk = 1'b0;
      it.e.hw = ((k % 8) < 4) ? 3'b010 : 3'b000;
      it.e.fm = ((k % 8) < 4) ? 3'b001 : 3'b000;
      it.tag  = tag;
      it.idx  = push_idx;
      push_idx++;
      q.push_back(it);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Leaves the bench #1 after the reset edge: cycle index 0, reset released.
  task automatic start_test();
    step();
    reset      = 1'b0;
    sensor     = 1'b0;
    ped_req    = 1'b0;
    flash_mode = 1'b0;
    step();
    reset    = 1'b1;
    push_idx = 0;
  endtask

  always @(negedge clk) begin
    item_t it;
    exp_t  got;
    if (q.size() > 0) begin
      it  = q.pop_front();
      got = {phase, highway, farm, walk};
      n_cmp++;
      if (got !== it.e) begin
        n_bad++;
        $display("FAIL %s[%0d]: got phase=%0d hwy=%b farm=%b walk=%b, expected phase=%0d hwy=%b farm=%b walk=%b",
                 it.tag, it.idx, got.ph, got.hw, got.fm, got.wk, it.e.ph, it.e.hw, it.e.fm, it.e.wk);
      end
    end
  end

  initial begin
    // idle road: highway green forever
    start_test();
    push_seg("idle_hg", P_HG, 100, 1'b0);
    run(99);

    // sensor held: full cycle with max-green cap
    start_test();
    sensor = 1'b1;
    push_seg("sens_hg", P_HG, 8, 1'b0);
    push_seg("sens_hy", P_HY, 3, 1'b0);
    push_seg("sens_arf", P_AR_F, 2, 1'b0);
    push_seg("sens_fg", P_FG, 12, 1'b0);
    push_seg("sens_fy", P_FY, 3, 1'b0);
    push_seg("sens_arh", P_AR_H, 2, 1'b0);
    push_seg("sens_hg2", P_HG, 8, 1'b0);
    run(37);

    // sensor drops on FG entry: min green
    start_test();
    sensor = 1'b1;
    push_seg("min_hg", P_HG, 8, 1'b0);
    push_seg("min_hy", P_HY, 3, 1'b0);
    push_seg("min_arf", P_AR_F, 2, 1'b0);
    push_seg("min_fg", P_FG, 4, 1'b0);
    push_seg("min_fy", P_FY, 3, 1'b0);
    push_seg("min_arh", P_AR_H, 2, 1'b0);
    push_seg("min_hg2", P_HG, 10, 1'b0);
    run(13);
    sensor = 1'b0;
    run(18);

    // single pedestrian pulse: walk phase, then request consumed
    start_test();
    ped_req = 1'b1;
    push_seg("ped_hg", P_HG, 8, 1'b0);
    push_seg("ped_hy", P_HY, 3, 1'b0);
    push_seg("ped_arf", P_AR_F, 2, 1'b0);
    push_seg("ped_fg", P_FG, 6, 1'b1);
    push_seg("ped_fy", P_FY, 3, 1'b0);
    push_seg("ped_arh", P_AR_H, 2, 1'b0);
    push_seg("ped_hg2", P_HG, 10, 1'b0);
    step();
    ped_req = 1'b0;
    run(32);

    // flash mid-FG, then release through AR_H
    start_test();
    sensor = 1'b1;
    push_seg("fl_hg", P_HG, 8, 1'b0);
    push_seg("fl_hy", P_HY, 3, 1'b0);
    push_seg("fl_arf", P_AR_F, 2, 1'b0);
    push_seg("fl_fg", P_FG, 6, 1'b0);
    push_flash("fl_flash", 16);
    push_seg("fl_arh", P_AR_H, 2, 1'b0);
    push_seg("fl_hg2", P_HG, 8, 1'b0);
    push_seg("fl_hy2", P_HY, 3, 1'b0);
    run(18);
    flash_mode = 1'b1;
    run(16);
    flash_mode = 1'b0;
    run(13);

    // reset mid-HY with a pending pedestrian request
    start_test();
    ped_req = 1'b1;
    push_seg("rst_hg", P_HG, 8, 1'b0);
    push_seg("rst_hy", P_HY, 2, 1'b0);
    push_seg("rst_hg2", P_HG, 12, 1'b0);
    step();
    ped_req = 1'b0;
    run(8);
    reset = 1'b0;
    step();
    reset = 1'b1;
    run(11);

    for (int k = 0; k < 5 && q.size() > 0; k++) step();
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
